// File: rtl/phv_queue_arb.sv
// phv_queue_arb: four per-queue PHV FIFOs merged round-robin into one registered
// stream for the deparser, with saturating per-queue drop counters.
module phv_queue_arb #(
    parameter int PHV_LEN          = 1024,
    parameter int C_NUM_QUEUES     = 4,
    parameter int QUEUE_DEPTH_BITS = 2,
    parameter int DROP_CNT_WIDTH   = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [PHV_LEN-1:0]                     phv_in_0,
    input  logic [PHV_LEN-1:0]                     phv_in_1,
    input  logic [PHV_LEN-1:0]                     phv_in_2,
    input  logic [PHV_LEN-1:0]                     phv_in_3,
    input  logic                                   phv_in_valid_0,
    input  logic                                   phv_in_valid_1,
    input  logic                                   phv_in_valid_2,
    input  logic                                   phv_in_valid_3,
    output logic                                   phv_fifo_ready_0,
    output logic                                   phv_fifo_ready_1,
    output logic                                   phv_fifo_ready_2,
    output logic                                   phv_fifo_ready_3,
    output logic [PHV_LEN-1:0]                     phv_out,
    output logic                                   phv_out_valid,
    output logic [1:0]                             phv_out_queue,
    input  logic                                   phv_out_ready,
    output logic [C_NUM_QUEUES*DROP_CNT_WIDTH-1:0] drop_cnt
);
    localparam int DEPTH = 1 << QUEUE_DEPTH_BITS;

    typedef logic [QUEUE_DEPTH_BITS-1:0] ptr_t;
    typedef logic [QUEUE_DEPTH_BITS:0]   occ_t;
    typedef logic [DROP_CNT_WIDTH-1:0]   cnt_t;
    typedef logic [1:0]                  qid_t;

    logic [PHV_LEN-1:0]      phv_in [C_NUM_QUEUES];
    logic [C_NUM_QUEUES-1:0] phv_in_valid;
    logic [C_NUM_QUEUES-1:0] phv_fifo_ready;

    assign phv_in[0] = phv_in_0;
    assign phv_in[1] = phv_in_1;
    assign phv_in[2] = phv_in_2;
    assign phv_in[3] = phv_in_3;
    assign phv_in_valid = {phv_in_valid_3, phv_in_valid_2, phv_in_valid_1, phv_in_valid_0};

    logic [PHV_LEN-1:0] fifo_mem [C_NUM_QUEUES][DEPTH];

    ptr_t wr_ptr_q   [C_NUM_QUEUES];
    ptr_t wr_ptr_d   [C_NUM_QUEUES];
    ptr_t rd_ptr_q   [C_NUM_QUEUES];
    ptr_t rd_ptr_d   [C_NUM_QUEUES];
    occ_t occ_q      [C_NUM_QUEUES];
    occ_t occ_d      [C_NUM_QUEUES];
    cnt_t drop_cnt_q [C_NUM_QUEUES];
    cnt_t drop_cnt_d [C_NUM_QUEUES];

    logic [PHV_LEN-1:0] phv_out_q, phv_out_d;
    logic               phv_out_valid_q, phv_out_valid_d;
    qid_t               phv_out_queue_q, phv_out_queue_d;
    qid_t               rr_ptr_q, rr_ptr_d;

    logic                    load_en;
    logic                    grant_found;
    qid_t                    grant_id;
    qid_t                    scan_idx;
    logic [C_NUM_QUEUES-1:0] pop;
    logic [C_NUM_QUEUES-1:0] wr_en;
    logic [C_NUM_QUEUES-1:0] drop;

    // Round-robin scan starting at rr_ptr_q; only runs when the output register can load.
    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        load_en     = ~phv_out_valid_q | phv_out_ready;
        grant_found = 1'b0;
        grant_id    = rr_ptr_q;
        scan_idx    = rr_ptr_q;
        for (int i = 0; i < C_NUM_QUEUES; i++) begin
            scan_idx = rr_ptr_q + qid_t'(i);
            if (load_en && !grant_found && occ_q[scan_idx] != '0) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
        end
        pop = '0;
        if (grant_found) begin
            pop[grant_id] = 1'b1;
        end
    end

    // A pop in the same cycle frees the slot, so a write to a full queue is still legal.
    always_comb begin
        for (int n = 0; n < C_NUM_QUEUES; n++) begin
            wr_en[n]          = phv_in_valid[n] && (occ_q[n] != occ_t'(DEPTH) || pop[n]);
            drop[n]           = phv_in_valid[n] && !wr_en[n];
            wr_ptr_d[n]       = wr_ptr_q[n] + ptr_t'(wr_en[n]);
            rd_ptr_d[n]       = rd_ptr_q[n] + ptr_t'(pop[n]);
            occ_d[n]          = occ_q[n] + occ_t'(wr_en[n]) - occ_t'(pop[n]);
            drop_cnt_d[n]     = (drop[n] && drop_cnt_q[n] != '1) ? drop_cnt_q[n] + cnt_t'(1)
                                                                 : drop_cnt_q[n];
            phv_fifo_ready[n] = occ_q[n] < occ_t'(DEPTH - 1);
        end
    end

    always_comb begin
        phv_out_d       = phv_out_q;
        phv_out_valid_d = phv_out_valid_q;
        phv_out_queue_d = phv_out_queue_q;
        rr_ptr_d        = rr_ptr_q;
        if (load_en) begin
            if (grant_found) begin
                phv_out_d       = fifo_mem[grant_id][rd_ptr_q[grant_id]];
                phv_out_valid_d = 1'b1;
                phv_out_queue_d = grant_id;
                rr_ptr_d        = grant_id + qid_t'(1);
            end else begin
                phv_out_valid_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q        <= '{default: '0};
            rd_ptr_q        <= '{default: '0};
            occ_q           <= '{default: '0};
            drop_cnt_q      <= '{default: '0};
            phv_out_q       <= '0;
            phv_out_valid_q <= 1'b0;
            phv_out_queue_q <= '0;
            rr_ptr_q        <= '0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            occ_q           <= occ_d;
            drop_cnt_q      <= drop_cnt_d;
            phv_out_q       <= phv_out_d;
            phv_out_valid_q <= phv_out_valid_d;
            phv_out_queue_q <= phv_out_queue_d;
            rr_ptr_q        <= rr_ptr_d;
        end
    end

    // NOTE: the storage array is not reset; occupancy and pointers alone define which
    // entries are live, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        for (int n = 0; n < C_NUM_QUEUES; n++) begin
            if (wr_en[n]) begin
                fifo_mem[n][wr_ptr_q[n]] <= phv_in[n];
            end
        end
    end

    assign phv_fifo_ready_0 = phv_fifo_ready[0];
    assign phv_fifo_ready_1 = phv_fifo_ready[1];
    assign phv_fifo_ready_2 = phv_fifo_ready[2];
    assign phv_fifo_ready_3 = phv_fifo_ready[3];
    assign phv_out          = phv_out_q;
    assign phv_out_valid    = phv_out_valid_q;
    assign phv_out_queue    = phv_out_queue_q;
    assign drop_cnt         = {drop_cnt_q[3], drop_cnt_q[2], drop_cnt_q[1], drop_cnt_q[0]};

endmodule

// File: tb/tb_phv_queue_arb.sv
// tb_phv_queue_arb: table-driven directed vectors, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_phv_queue_arb;
    localparam int PHV_LEN = 1024;
    localparam int NQ      = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [PHV_LEN-1:0] din [NQ];
    logic [NQ-1:0]      vin = '0;
    logic               rdy = 1'b0;

    logic               fr0, fr1, fr2, fr3;
    logic [PHV_LEN-1:0] phv_out;
    logic               phv_out_valid;
    logic [1:0]         phv_out_queue;
    logic [63:0]        drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    phv_queue_arb dut (
        .clk              (clk),
        .reset            (rst),
        .phv_in_0         (din[0]),
        .phv_in_1         (din[1]),
        .phv_in_2         (din[2]),
        .phv_in_3         (din[3]),
        .phv_in_valid_0   (vin[0]),
        .phv_in_valid_1   (vin[1]),
        .phv_in_valid_2   (vin[2]),
        .phv_in_valid_3   (vin[3]),
        .phv_fifo_ready_0 (fr0),
        .phv_fifo_ready_1 (fr1),
        .phv_fifo_ready_2 (fr2),
        .phv_fifo_ready_3 (fr3),
        .phv_out          (phv_out),
        .phv_out_valid    (phv_out_valid),
        .phv_out_queue    (phv_out_queue),
        .phv_out_ready    (rdy),
        .drop_cnt         (drop_cnt)
    );

    // Reference model: a bounded queue per input plus one output holding slot.
    typedef logic [PHV_LEN-1:0] phv_q_t [$];
    phv_q_t             mq [NQ];
    logic               m_valid;
    logic [PHV_LEN-1:0] m_out;
    int                 m_queue;
    int                 m_rr;
    int                 m_drop [NQ];

    task automatic check(input string name, input logic [PHV_LEN-1:0] act,
                         input logic [PHV_LEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got[127:0]=%h want[127:0]=%h", name, act[127:0], exp[127:0]);
        end
    endtask

    task automatic model_step();
        logic               load_en;
        int                 g;
        logic [PHV_LEN-1:0] head;
        if (rst) begin
            for (int n = 0; n < NQ; n++) begin
                mq[n].delete();
                m_drop[n] = 0;
            end
            m_valid = 1'b0;
            m_out   = '0;
            m_queue = 0;
            m_rr    = 0;
            return;
        end
        load_en = !m_valid || rdy;
        g       = -1;
        head    = '0;
        if (load_en) begin
            for (int i = 0; i < NQ; i++) begin
                if (g < 0 && mq[(m_rr + i) % NQ].size() > 0) g = (m_rr + i) % NQ;
            end
        end
        if (g >= 0) head = mq[g].pop_front();
        for (int n = 0; n < NQ; n++) begin
            if (vin[n]) begin
                if (mq[n].size() < 4) mq[n].push_back(din[n]);
                else if (m_drop[n] < 65535) m_drop[n]++;
            end
        end
        if (load_en) begin
            if (g >= 0) begin
                m_out   = head;
                m_queue = g;
                m_valid = 1'b1;
                m_rr    = (g + 1) % NQ;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic model_compare();
        logic [NQ-1:0] exp_fr;
        logic [63:0]   exp_drop;
        for (int n = 0; n < NQ; n++) begin
            exp_fr[n]            = mq[n].size() < 3;
            exp_drop[n*16 +: 16] = 16'(m_drop[n]);
        end
        check("model_valid", PHV_LEN'(phv_out_valid), PHV_LEN'(m_valid));
        if (m_valid) begin
            check("model_queue", PHV_LEN'(phv_out_queue), PHV_LEN'(m_queue));
            check("model_data", phv_out, m_out);
        end
        check("model_ready", PHV_LEN'({fr3, fr2, fr1, fr0}), PHV_LEN'(exp_fr));
        check("model_drop", PHV_LEN'(drop_cnt), PHV_LEN'(exp_drop));
    endtask

    // Inputs are set before the call; the model consumes them at the same edge as the DUT.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        model_compare();
    endtask

    task automatic set_all(input logic [PHV_LEN-1:0] d);
        for (int n = 0; n < NQ; n++) din[n] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vin = '0;
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  vin;
        logic [15:0] data;
        logic        rdy;
        logic        ev;
        logic [1:0]  eq;
        logic [15:0] ed;
        logic [3:0]  efr;
        logic [15:0] edrop1;
    } vec_t;

    vec_t tbl [$];

    function automatic void add(string name, logic r, logic [3:0] v, logic [15:0] d, logic rd,
                                logic ev, logic [1:0] eq, logic [15:0] ed, logic [3:0] efr,
                                logic [15:0] edrop1);
        vec_t t;
        t.name = name; t.rst = r; t.vin = v; t.data = d; t.rdy = rd;
        t.ev = ev; t.eq = eq; t.ed = ed; t.efr = efr; t.edrop1 = edrop1;
        tbl.push_back(t);
    endfunction

    initial begin
        set_all('0);

        // Single beat into queue 2: visible two edges after the write, for one cycle.
        add("sb_rst",  1, 4'b0000, 16'h0000, 1, 0, 0, 16'h0000, 4'b1111, 0);
        add("sb_wr",   0, 4'b0100, 16'h00A5, 1, 0, 0, 16'h0000, 4'b1111, 0);
        add("sb_out",  0, 4'b0000, 16'h0000, 1, 1, 2, 16'h00A5, 4'b1111, 0);
        add("sb_gone", 0, 4'b0000, 16'h0000, 1, 0, 0, 16'h0000, 4'b1111, 0);
        add("sb_idle", 0, 4'b0000, 16'h0000, 1, 0, 0, 16'h0000, 4'b1111, 0);
        // Backpressure: a queue-0 beat sits stalled in the output, then queue 1 fills.
        add("bp_rst",  1, 4'b0000, 16'h0000, 0, 0, 0, 16'h0000, 4'b1111, 0);
        add("bp_q0",   0, 4'b0001, 16'h00A0, 0, 0, 0, 16'h0000, 4'b1111, 0);
        add("bp_hold", 0, 4'b0000, 16'h0000, 0, 1, 0, 16'h00A0, 4'b1111, 0);
        add("bp_w1",   0, 4'b0010, 16'h0011, 0, 1, 0, 16'h00A0, 4'b1111, 0);
        add("bp_w2",   0, 4'b0010, 16'h0012, 0, 1, 0, 16'h00A0, 4'b1111, 0);
        add("bp_w3",   0, 4'b0010, 16'h0013, 0, 1, 0, 16'h00A0, 4'b1101, 0);
        add("bp_w4",   0, 4'b0010, 16'h0014, 0, 1, 0, 16'h00A0, 4'b1101, 0);
        add("bp_w5",   0, 4'b0010, 16'h0015, 0, 1, 0, 16'h00A0, 4'b1101, 1);
        add("bp_o1",   0, 4'b0000, 16'h0000, 1, 1, 1, 16'h0011, 4'b1101, 1);
        add("bp_o2",   0, 4'b0000, 16'h0000, 1, 1, 1, 16'h0012, 4'b1111, 1);
        add("bp_o3",   0, 4'b0000, 16'h0000, 1, 1, 1, 16'h0013, 4'b1111, 1);
        add("bp_o4",   0, 4'b0000, 16'h0000, 1, 1, 1, 16'h0014, 4'b1111, 1);
        add("bp_end",  0, 4'b0000, 16'h0000, 1, 0, 0, 16'h0000, 4'b1111, 1);
        // Multicast to queues 0 and 3 in one cycle.
        add("mc_rst",  1, 4'b0000, 16'h0000, 1, 0, 0, 16'h0000, 4'b1111, 0);
        add("mc_wr",   0, 4'b1001, 16'h1234, 1, 0, 0, 16'h0000, 4'b1111, 0);
        add("mc_q0",   0, 4'b0000, 16'h0000, 1, 1, 0, 16'h1234, 4'b1111, 0);
        add("mc_q3",   0, 4'b0000, 16'h0000, 1, 1, 3, 16'h1234, 4'b1111, 0);
        add("mc_end",  0, 4'b0000, 16'h0000, 1, 0, 0, 16'h0000, 4'b1111, 0);

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            vin = tbl[i].vin;
            rdy = tbl[i].rdy;
            set_all(PHV_LEN'(tbl[i].data));
            cycle();
            check({tbl[i].name, "_valid"}, PHV_LEN'(phv_out_valid), PHV_LEN'(tbl[i].ev));
            if (tbl[i].ev) begin
                check({tbl[i].name, "_queue"}, PHV_LEN'(phv_out_queue), PHV_LEN'(tbl[i].eq));
                check({tbl[i].name, "_data"}, phv_out, PHV_LEN'(tbl[i].ed));
            end
            check({tbl[i].name, "_ready"}, PHV_LEN'({fr3, fr2, fr1, fr0}), PHV_LEN'(tbl[i].efr));
            check({tbl[i].name, "_drop1"}, PHV_LEN'(drop_cnt[31:16]), PHV_LEN'(tbl[i].edrop1));
        end
        rst = 1'b0;
        vin = '0;

        // Round-robin: three PHVs per queue preloaded, then drained with no gaps.
        do_reset();
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vin = 4'b1111;
            for (int n = 0; n < NQ; n++) din[n] = PHV_LEN'({8'(n), 8'(k)});
            cycle();
        end
        vin = '0;
        check("rr_first_valid", PHV_LEN'(phv_out_valid), PHV_LEN'(1));
        check("rr_first_queue", PHV_LEN'(phv_out_queue), PHV_LEN'(0));
        check("rr_first_data", phv_out, PHV_LEN'(16'h0000));
        rdy = 1'b1;
        for (int i = 1; i < 12; i++) begin
            cycle();
            check("rr_valid", PHV_LEN'(phv_out_valid), PHV_LEN'(1));
            check("rr_queue", PHV_LEN'(phv_out_queue), PHV_LEN'(i % 4));
            check("rr_data", phv_out, PHV_LEN'({8'(i % 4), 8'(i / 4)}));
        end
        cycle();
        check("rr_drained", PHV_LEN'(phv_out_valid), PHV_LEN'(0));

        // Stall hold: output frozen and queue 2 stays at three entries while not ready.
        do_reset();
        rdy = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            vin = 4'b0100;
            set_all(PHV_LEN'(16'h0020 + 16'(k)));
            cycle();
        end
        vin = '0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            check("stall_valid", PHV_LEN'(phv_out_valid), PHV_LEN'(1));
            check("stall_data", phv_out, PHV_LEN'(16'h0021));
            check("stall_queue", PHV_LEN'(phv_out_queue), PHV_LEN'(2));
            check("stall_ready", PHV_LEN'({fr3, fr2, fr1, fr0}), PHV_LEN'(4'b1011));
        end
        rdy = 1'b1;
        cycle();
        check("stall_next", phv_out, PHV_LEN'(16'h0022));
        check("stall_next_valid", PHV_LEN'(phv_out_valid), PHV_LEN'(1));
        for (int c = 0; c < 3; c++) cycle();

        // Reset mid-stream: two buffered plus one on the output are discarded.
        do_reset();
        rdy = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            vin = 4'b0001;
            set_all(PHV_LEN'(16'h0030 + 16'(k)));
            cycle();
        end
        vin = '0;
        check("mid_pre_valid", PHV_LEN'(phv_out_valid), PHV_LEN'(1));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_valid", PHV_LEN'(phv_out_valid), PHV_LEN'(0));
        check("mid_out", phv_out, '0);
        check("mid_queue", PHV_LEN'(phv_out_queue), PHV_LEN'(0));
        check("mid_drop", PHV_LEN'(drop_cnt), '0);
        check("mid_ready", PHV_LEN'({fr3, fr2, fr1, fr0}), PHV_LEN'(4'b1111));
        rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            check("mid_no_stale", PHV_LEN'(phv_out_valid), PHV_LEN'(0));
        end

        // Randomized traffic with phases of light and heavy backpressure.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int n = 0; n < NQ; n++) begin
                vin[n] = ($urandom_range(0, 99) < 40);
                for (int w = 0; w < PHV_LEN / 32; w++) din[n][w*32 +: 32] = $urandom();
            end
            if ((c / 200) % 2 == 0) rdy = ($urandom_range(0, 9) < 8);
            else rdy = ($urandom_range(0, 9) < 2);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
